// File: rtl/noc_flit_pkg.sv
// Shared flit geometry and arbiter types for the reduce/inject path.
// Field positions are functions of payload width so every block derives them the same way.
package noc_flit_pkg;

    localparam int FlitHeaderBits = 50;
    localparam int PayloadLsb     = 0;

    function automatic int flit_width(input int payload_width);
        return payload_width + FlitHeaderBits;
    endfunction

    function automatic int valid_bit_pos(input int payload_width);
        return flit_width(payload_width) - 1;
    endfunction

    function automatic int flit_child_width(input int payload_width, input int children_width);
        return flit_width(payload_width) + children_width;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_skid_buf.sv
// Per-requester holding FIFO: drops on push-to-full unless a pop frees the slot in the same cycle,
// and latches a sticky overflow flag when it does drop.
module arb_skid_buf #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AddrWidth = $clog2(Depth);

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [AddrWidth-1:0] rd_ptr_q;
    logic [AddrWidth:0]   count_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AddrWidth+1)'(Depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AddrWidth+1)'(1);
                2'b01:   count_q <= count_q - (AddrWidth+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the count guards every read, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/reduce_inject_arbiter.sv
// Merges NUM_RED reduce-unit result streams and one application stream onto a router inject port.
// Round-robin over all requesters; define REDUCE_PRIORITY_EN to make reduce buffers always beat the app.
module reduce_inject_arbiter
    import noc_flit_pkg::*;
#(
    parameter int lg_numprocs  = 3,
    parameter int PayloadWidth = 32,
    parameter int NUM_RED      = 2,
    parameter int BUF_DEPTH    = 2,
    localparam int ChildrenWidth  = lg_numprocs,
    localparam int FlitWidth      = flit_width(PayloadWidth),
    localparam int ValidBitPos    = valid_bit_pos(PayloadWidth),
    localparam int FlitChildWidth = flit_child_width(PayloadWidth, ChildrenWidth),
    localparam int GrantWidth     = $clog2(NUM_RED + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RED*FlitWidth-1:0] red_flit,
    input  logic [NUM_RED-1:0]          red_valid,
    input  logic [FlitChildWidth-1:0]   app_flit,
    input  logic                        app_valid,
    output logic                        app_ready,
    output logic [FlitChildWidth-1:0]   inj_flit,
    output logic                        inj_valid,
    input  logic                        inj_ready,
    output logic [GrantWidth-1:0]       grant_id,
    output logic [NUM_RED-1:0]          ovf
);

    localparam int NumReq = NUM_RED + 1;
    localparam logic [FlitChildWidth-1:0] ValidMask = FlitChildWidth'(1) << ValidBitPos;
    localparam logic [GrantWidth-1:0]     AppIdx    = GrantWidth'(NUM_RED);

    logic [FlitChildWidth-1:0] head [NUM_RED];
    logic [NUM_RED-1:0]        buf_empty;
    logic [NUM_RED-1:0]        buf_full;
    logic [NUM_RED-1:0]        buf_pop;
    logic [NumReq-1:0]         req;
    logic [GrantWidth-1:0]     rr_ptr_q;
    logic [GrantWidth-1:0]     rr_idx;
    logic [GrantWidth-1:0]     winner;
    logic                      found;
    logic                      load;
    logic [FlitChildWidth-1:0] winner_flit;
    arb_state_t                state_q;
    arb_state_t                state_d;

    for (genvar i = 0; i < NUM_RED; i++) begin : g_buf
        arb_skid_buf #(
            .Width(FlitChildWidth),
            .Depth(BUF_DEPTH)
        ) u_buf (
            .clk      (clk),
            .rst      (rst),
            .push     (red_valid[i]),
            .push_data({{ChildrenWidth{1'b0}}, red_flit[i*FlitWidth +: FlitWidth]}),
            .pop      (buf_pop[i]),
            .head     (head[i]),
            .empty    (buf_empty[i]),
            .full     (buf_full[i]),
            .overflow (ovf[i])
        );

        assign buf_pop[i] = load && (winner == GrantWidth'(i));

        a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
            buf_pop[i] |-> !buf_empty[i]);
        a_drop_sets_ovf: assert property (@(posedge clk) disable iff (!rst)
            red_valid[i] && buf_full[i] && !buf_pop[i] |=> ovf[i]);
    end

    // First requester at or after the pointer wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req    = {app_valid, ~buf_empty};
        found  = 1'b0;
        winner = '0;
        rr_idx = '0;
`ifdef REDUCE_PRIORITY_EN
        if (!(&buf_empty)) req[NUM_RED] = 1'b0;
`endif
        for (int off = 0; off < NumReq; off++) begin
            rr_idx = GrantWidth'((int'(rr_ptr_q) + off) % NumReq);
            if (!found && req[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        winner_flit = app_flit;
        for (int i = 0; i < NUM_RED; i++) begin
            if (winner == GrantWidth'(i)) winner_flit = head[i];
        end
    end

    assign load = found && ((state_q == IDLE) || inj_ready);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = SEND;
            SEND:    if (inj_ready) state_d = found ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inj_valid = (state_q == SEND);
        app_ready = load && (winner == AppIdx);
    end

    // The stored valid bit is forced on load and cleared on drain, so it always mirrors inj_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_flit <= '0;
            grant_id <= '0;
            rr_ptr_q <= '0;
        end else if (load) begin
            inj_flit <= winner_flit | ValidMask;
            grant_id <= winner;
            rr_ptr_q <= (winner == AppIdx) ? '0 : winner + GrantWidth'(1);
        end else if ((state_q == SEND) && inj_ready) begin
            inj_flit[ValidBitPos] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reduce_inject_arbiter.sv
// Scoreboard bench: a queue-based behavioural model predicts each injected flit; a monitor checks it.
module tb_reduce_inject_arbiter;

    localparam int LG    = 3;
    localparam int PW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 2;
    localparam int FW    = PW + 50;
    localparam int VBP   = FW - 1;
    localparam int FCW   = FW + LG;
    localparam int NQ    = NR + 1;
    localparam int GW    = $clog2(NR + 1);
    localparam logic [FCW-1:0] VMASK = FCW'(1) << VBP;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR*FW-1:0]  red_flit = '0;
    logic [NR-1:0]     red_valid = '0;
    logic [FCW-1:0]    app_flit = '0;
    logic              app_valid = 1'b0;
    logic              app_ready;
    logic [FCW-1:0]    inj_flit;
    logic              inj_valid;
    logic              inj_ready = 1'b1;
    logic [GW-1:0]     grant_id;
    logic [NR-1:0]     ovf;

    reduce_inject_arbiter #(
        .lg_numprocs (LG),
        .PayloadWidth(PW),
        .NUM_RED     (NR),
        .BUF_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .red_flit (red_flit),
        .red_valid(red_valid),
        .app_flit (app_flit),
        .app_valid(app_valid),
        .app_ready(app_ready),
        .inj_flit (inj_flit),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .grant_id (grant_id),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [GW-1:0]  gid;
        logic [FCW-1:0] flit;
    } exp_t;

    exp_t           exp_q[$];
    logic [FCW-1:0] mq [NR][$];
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[FW-1:0];
    endfunction

    // Reference model: per-requester queues, one output slot, round-robin pointer.
    int         m_ptr = 0;
    logic       m_valid = 1'b0;
    logic [NR-1:0] m_ovf = '0;
    bit [NQ-1:0] m_req;
    bit         m_can_load;
    int         m_win;
    exp_t       m_e;

    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            exp_q.delete();
            m_ptr   = 0;
            m_valid = 1'b0;
            m_ovf   = '0;
            check("reset_inj_valid", inj_valid, 0);
            check("reset_ovf", ovf, 0);
            check("reset_app_ready", app_ready, 0);
            check("reset_inj_flit", inj_flit, 0);
            check("reset_grant_id", grant_id, 0);
        end else begin
            check("inj_valid", inj_valid, m_valid);
            check("ovf", ovf, m_ovf);
            m_can_load = !m_valid || inj_ready;
            for (int i = 0; i < NR; i++) m_req[i] = (mq[i].size() > 0);
            m_req[NR] = app_valid;
`ifdef REDUCE_PRIORITY_EN
            if (m_req[NR-1:0] != '0) m_req[NR] = 1'b0;
`endif
            m_win = -1;
            for (int off = 0; off < NQ; off++) begin
                if (m_win < 0 && m_req[(m_ptr + off) % NQ]) m_win = (m_ptr + off) % NQ;
            end
            check("app_ready", app_ready, m_can_load && (m_win == NR));
            if (m_can_load) begin
                if (m_win >= 0) begin
                    m_e.gid = GW'(m_win);
                    if (m_win == NR) m_e.flit = app_flit | VMASK;
                    else             m_e.flit = mq[m_win].pop_front() | VMASK;
                    exp_q.push_back(m_e);
                    m_valid = 1'b1;
                    m_ptr   = (m_win + 1) % NQ;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (red_valid[i]) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back({LG'(0), red_flit[i*FW +: FW]});
                    else                      m_ovf[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: whatever the DUT presents must be the oldest predicted flit.
    exp_t mon_e;
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            check("valid_bit", inj_flit[VBP], inj_valid);
            if (inj_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", inj_flit, $time);
                end else begin
                    mon_e = exp_q[0];
                    check("grant_id", grant_id, mon_e.gid);
                    check("inj_flit", inj_flit, mon_e.flit);
                    if (inj_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle_inputs();
        red_valid = '0;
        app_valid = 1'b0;
        inj_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_red(input int idx);
        red_flit[idx*FW +: FW] = rand_flit();
        red_valid = '0;
        red_valid[idx] = 1'b1;
        @(negedge clk);
        red_valid = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single pulse latency and field check.
        @(negedge clk);
        red_flit[FW-1:0] = FW'(32'hA5A5_A5A5);
        red_valid = 2'b01;
        @(negedge clk);
        red_valid = '0;
        #1 check("lat_not_early", inj_valid, 0);
        @(negedge clk);
        #1;
        check("lat_valid", inj_valid, 1);
        check("lat_grant", grant_id, 0);
        check("lat_payload", inj_flit[PW-1:0], 32'hA5A5_A5A5);
        check("lat_children", inj_flit[FCW-1:FW], 0);

        // Every requester asserting continuously.
        do_reset();
        red_valid = '1;
        app_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            red_flit = {rand_flit(), rand_flit()};
            app_flit = {$urandom, $urandom, $urandom};
            @(negedge clk);
        end
        idle_inputs();
        repeat (8) @(negedge clk);

        // Stalled output while requester 1 overfills.
        do_reset();
        inj_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulse_red(1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1 check("stall_ovf1", ovf[1], 1);
        @(negedge clk);
        inj_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-send with buffered flits.
        do_reset();
        inj_ready = 1'b0;
        for (int k = 0; k < 4; k++) pulse_red(0);
        repeat (2) @(negedge clk);
        #1 check("pre_rst_valid", inj_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", inj_valid, 0);
        check("async_rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        inj_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1 check("post_rst_idle", inj_valid, 0);

        // Full buffer drained while new pushes arrive each cycle.
        do_reset();
        inj_ready = 1'b0;
        for (int k = 0; k < 3; k++) pulse_red(0);
        inj_ready = 1'b1;
        red_valid = 2'b01;
        for (int c = 0; c < 6; c++) begin
            red_flit[FW-1:0] = rand_flit();
            @(negedge clk);
        end
        idle_inputs();
        repeat (6) @(negedge clk);
        #1 check("full_pushpop_ovf", ovf, 0);

        // Randomised traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            red_flit  = {rand_flit(), rand_flit()};
            red_valid = NR'($urandom_range(0, (1 << NR) - 1));
            app_flit  = {$urandom, $urandom, $urandom};
            app_valid = ($urandom_range(0, 3) != 0);
            inj_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        idle_inputs();
        repeat (12) @(negedge clk);
        #1 check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
